// File: rtl/cnn_pkg.sv
// Shared constants for the CNN datapath.
// Holds the MAC output width (derived from image and kernel operand widths),
// the default quantizer widths, and the guard bits used by the rounding and
// saturation stages so every block agrees on intermediate sizes.
package cnn_pkg;

  localparam int IMG_WIDTH       = 16;
  localparam int KER_WIDTH       = 16;
  localparam int MAC_WIDTH       = IMG_WIDTH + KER_WIDTH + 1;

  localparam int BIAS_WIDTH_DEF  = 16;
  localparam int OUT_WIDTH_DEF   = 16;
  localparam int SHIFT_WIDTH_DEF = 5;

  // acc + bias needs one extra bit so the sum can never overflow.
  localparam int SUM_GUARD       = 1;
  // Adding the half-LSB rounding constant needs one more bit of headroom.
  localparam int ROUND_GUARD     = 1;

  localparam int SAT_CNT_WIDTH   = 16;

endpackage

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears pointers)
//   push/wdata: write request and data
//   pop       : read request; ignored when empty
//   rdata     : head entry, zero when empty
//   valid     : FIFO not empty
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter. A push to a full FIFO is accepted only when a
// pop frees a slot in the same cycle.
module fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign valid = ~empty;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; emptiness comes from the
  // pointers, and leaving the array reset-free lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/result_quantize.sv
// Accumulator result quantizer.
// Three-stage pipeline: (1) acc + bias, (2) round-half-up arithmetic right
// shift, (3) optional ReLU and saturation into a FWFT output FIFO.
// Ports:
//   acc/acc_val/acc_rdy : accumulator input strobe; acc_rdy is credit based
//   bias/shift/relu_en  : per-item controls, sampled with acc_val
//   out_data/out_val/out_rdy : quantized output stream (FIFO head)
//   err_clr/err_overflow: sticky flag for strobes issued while acc_rdy low
//   sat_cnt             : saturating count of clipped results
module result_quantize
  import cnn_pkg::*;
#(
  parameter int ACC_WIDTH   = MAC_WIDTH,
  parameter int BIAS_WIDTH  = BIAS_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic                         acc_val,
  output logic                         acc_rdy,
  input  logic signed [BIAS_WIDTH-1:0] bias,
  input  logic [SHIFT_WIDTH-1:0]       shift,
  input  logic                         relu_en,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_val,
  input  logic                         out_rdy,
  input  logic                         err_clr,
  output logic                         err_overflow,
  output logic [SAT_CNT_WIDTH-1:0]     sat_cnt
);

  localparam int SW = ACC_WIDTH + SUM_GUARD;
  localparam int RW = SW + ROUND_GUARD;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic signed [RW-1:0] SAT_MAX =
    {{(RW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN =
    {{(RW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic                     pop, accept;
  logic [CW-1:0]            credits_q, credits_d;

  logic                     s1_vld_q;
  logic signed [SW-1:0]     s1_sum_q, s1_sum_d;
  logic [SHIFT_WIDTH-1:0]   s1_shift_q;
  logic                     s1_relu_q;

  logic                     s2_vld_q;
  logic signed [RW-1:0]     s2_val_q, s2_val_d;
  logic                     s2_relu_q;

  logic signed [RW-1:0]     rnd_inc, rnd_sum, relu_val;
  logic                     clip_hi, clip_lo;
  logic signed [OUT_WIDTH-1:0] q_data;

  logic                     err_q, err_d;
  logic [SAT_CNT_WIDTH-1:0] sat_q, sat_d;

  // A pop this cycle returns a credit immediately, so a full buffer that is
  // draining can still accept a new item in the same cycle.
  assign pop     = out_val & out_rdy;
  assign acc_rdy = (credits_q < CW'(FIFO_DEPTH)) | pop;
  assign accept  = acc_val & acc_rdy;

  assign err_overflow = err_q;
  assign sat_cnt      = sat_q;

  // NOTE: every combinational output gets a default before any condition so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    s1_sum_d = SW'(acc) + SW'(bias);

    // Half-LSB constant for round-half-up; shift==0 adds nothing.
    rnd_inc  = (s1_shift_q == '0) ? '0 : (RW'(1) <<< (s1_shift_q - 1'b1));
    rnd_sum  = RW'(s1_sum_q) + rnd_inc;
    s2_val_d = rnd_sum >>> s1_shift_q;

    // ReLU first: a clamp to zero never counts as saturation.
    relu_val = (s2_relu_q && s2_val_q[RW-1]) ? '0 : s2_val_q;
    clip_hi  = (relu_val > SAT_MAX);
    clip_lo  = (relu_val < SAT_MIN);
    q_data   = relu_val[OUT_WIDTH-1:0];
    if (clip_hi)      q_data = SAT_MAX[OUT_WIDTH-1:0];
    else if (clip_lo) q_data = SAT_MIN[OUT_WIDTH-1:0];

    credits_d = credits_q;
    case ({accept, pop})
      2'b10:   credits_d = credits_q + CW'(1);
      2'b01:   credits_d = credits_q - CW'(1);
      default: credits_d = credits_q;
    endcase

    // A fresh overflow beats a clear in the same cycle.
    err_d = (err_q & ~err_clr) | (acc_val & ~acc_rdy);

    sat_d = sat_q;
    if (s2_vld_q && (clip_hi || clip_lo) && (sat_q != '1))
      sat_d = sat_q + SAT_CNT_WIDTH'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_sum_q   <= '0;
      s1_shift_q <= '0;
      s1_relu_q  <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_val_q   <= '0;
      s2_relu_q  <= 1'b0;
      err_q      <= 1'b0;
      sat_q      <= '0;
    end else begin
      credits_q  <= credits_d;
      // Bias is consumed in stage 1; shift and relu_en ride along with the
      // operand so later input changes never touch in-flight items.
      s1_vld_q   <= accept;
      s1_sum_q   <= s1_sum_d;
      s1_shift_q <= shift;
      s1_relu_q  <= relu_en;
      s2_vld_q   <= s1_vld_q;
      s2_val_q   <= s2_val_d;
      s2_relu_q  <= s1_relu_q;
      err_q      <= err_d;
      sat_q      <= sat_d;
    end
  end

  // Credits guarantee a free slot for every item in flight, so the push is
  // never refused.
  fifo_fwft #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_vld_q),
    .wdata (q_data),
    .pop   (out_rdy),
    .rdata (out_data),
    .valid (out_val)
  );

endmodule

// File: tb/tb_result_quantize.sv
// Self-checking bench for result_quantize: the driver pushes expected
// results (with the cycle they should appear) into a scoreboard queue, and a
// separate monitor compares the DUT output stream against it every cycle.
module tb_result_quantize;

  logic               clk;
  logic               rst;
  logic signed [32:0] acc;
  logic               acc_val;
  logic               acc_rdy;
  logic signed [15:0] bias;
  logic [4:0]         shift;
  logic               relu_en;
  logic signed [15:0] out_data;
  logic               out_val;
  logic               out_rdy;
  logic               err_clr;
  logic               err_overflow;
  logic [15:0]        sat_cnt;

  result_quantize dut (
    .clk          (clk),
    .rst          (rst),
    .acc          (acc),
    .acc_val      (acc_val),
    .acc_rdy      (acc_rdy),
    .bias         (bias),
    .shift        (shift),
    .relu_en      (relu_en),
    .out_data     (out_data),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .err_clr      (err_clr),
    .err_overflow (err_overflow),
    .sat_cnt      (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint data;
    int     ready;
  } item_t;

  item_t  sb[$];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  bit     err_model = 1'b0;
  longint sat_model = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference quantizer: plain integer arithmetic on the specified rules.
  function automatic longint ref_q(input longint a, input longint b, input int sh,
                                   input bit relu, output bit clip);
    longint r;
    r = a + b;
    clip = 1'b0;
    if (sh > 0) r = (r + (longint'(1) <<< (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 32767) begin
      r = 32767;
      clip = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      clip = 1'b1;
    end
    return r;
  endfunction

  // One clock of stimulus; predicts acceptance from the bench's own
  // outstanding-item count and the head-ready time of the scoreboard.
  task automatic drive(input bit v, input longint a, input longint b, input int sh,
                       input bit relu, input bit ordy, input bit clr);
    bit     pop_now, exp_rdy, clip;
    longint q;
    @(posedge clk);
    #1;
    check("err_overflow", err_overflow, err_model);
    acc_val = v;
    acc     = 33'(a);
    bias    = 16'(b);
    shift   = 5'(sh);
    relu_en = relu;
    out_rdy = ordy;
    err_clr = clr;
    #1;
    pop_now = (sb.size() > 0) && (sb[0].ready <= cyc) && ordy;
    exp_rdy = (sb.size() < 4) || pop_now;
    check("acc_rdy", acc_rdy, exp_rdy);
    if (v && exp_rdy) begin
      q = ref_q(a, b, sh, relu, clip);
      sb.push_back('{q, cyc + 3});
      if (clip && sat_model < 65535) sat_model++;
    end
    err_model = (err_model && !clr) || (v && !exp_rdy);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0, ordy, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 64) begin
      drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    check("drain_within_budget", (n < 64) ? 1 : 0, 1);
    idle(3, 1'b1);
  endtask

  // Monitor: every mid-cycle, the head of the scoreboard is either due (and
  // must be on the output) or not (and out_val must be low).
  always @(negedge clk) begin
    bit exp_v;
    if (!rst) begin
      exp_v = (sb.size() > 0) && (sb[0].ready <= cyc);
      check("out_val", out_val, exp_v);
      if (exp_v) begin
        check("out_data", out_data, sb[0].data);
        if (out_rdy) void'(sb.pop_front());
      end
    end
  end

  initial begin
    longint ra, rb;
    logic signed [15:0] b16;
    rst = 1'b1; acc = '0; acc_val = 1'b0; bias = '0; shift = '0;
    relu_en = 1'b0; out_rdy = 1'b0; err_clr = 1'b0;

    #12;
    check("reset_out_val", out_val, 0);
    check("reset_out_data", out_data, 0);
    check("reset_err", err_overflow, 0);
    check("reset_sat_cnt", sat_cnt, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("post_reset_acc_rdy", acc_rdy, 1);

    // Basic rounding case with an explicit 3-cycle latency check.
    drive(1'b1, 1000, 24, 4, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("lat_not_early", out_val, 0);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    check("lat_out_val", out_val, 1);
    check("lat_out_data", out_data, 64);
    idle(2, 1'b1);

    // Negative rounding, then the same value clamped by ReLU.
    drive(1'b1, -40, 0, 3, 1'b0, 1'b1, 1'b0);
    drive(1'b1, -40, 0, 3, 1'b1, 1'b1, 1'b0);
    drain();
    check("relu_no_sat", sat_cnt, 0);

    // Saturation at both rails.
    drive(1'b1, 1 <<< 20, 0, 0, 1'b0, 1'b1, 1'b0);
    drain();
    check("sat_hi_cnt", sat_cnt, 1);
    drive(1'b1, -(1 <<< 20), 0, 0, 1'b0, 1'b1, 1'b0);
    drain();
    check("sat_lo_cnt", sat_cnt, 2);

    // Back-pressure: four accepted, fifth dropped with overflow flagged.
    for (int i = 0; i < 5; i++) drive(1'b1, 100 * (i + 1), i, 1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("overflow_set", err_overflow, 1);
    drain();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);

    // Overflow beats clear; then a strobe on a full FIFO rides a same-cycle pop.
    for (int i = 0; i < 4; i++) drive(1'b1, -7 * (i + 1), 3, 2, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    drive(1'b1, 5, 0, 0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 77, 1, 1, 1'b0, 1'b1, 1'b0);
    drain();
    check("full_pop_no_err", err_overflow, 0);

    // Asynchronous reset with two buffered and one in flight.
    drive(1'b1, 11, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 22, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    drive(1'b1, 33, 0, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    acc_val = 1'b0;
    #1;
    check("async_rst_out_val", out_val, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_sat", sat_cnt, 0);
    sb.delete();
    err_model = 1'b0;
    sat_model = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    idle(6, 1'b1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      ra  = {$urandom(), $urandom()};
      ra  = ra >>> $urandom_range(31, 60);
      b16 = 16'($urandom());
      rb  = b16;
      drive(($urandom_range(0, 9) < 6), ra, rb, $urandom_range(0, 31),
            $urandom_range(0, 1) == 1, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0));
    end
    drain();
    check("final_sat_cnt", sat_cnt, sat_model);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_quantize.md
RESULT_QUANTIZE -- requirements
Module: result_quantize

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 33, giving the signed accumulator input width (IMG_WIDTH+KER_WIDTH+1).
REQ-002 SHALL have parameter BIAS_WIDTH, default 16, giving the signed bias width.
REQ-003 SHALL have parameter OUT_WIDTH, default 16, giving the signed quantized output width.
REQ-004 SHALL have parameter SHIFT_WIDTH, default 5, giving the right-shift amount width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, giving the output buffer depth (power of two, >= 4).
REQ-006 SHALL have a single clock, clk (input, 1), and reset, rst (input, 1); rst is asynchronous and active-high.
REQ-007 acc  input  ACC_WIDTH  final signed accumulator result.
REQ-008 acc_val  input  1  one-cycle strobe marking acc as final.
REQ-009 acc_rdy  output  1  high when a new acc_val will be accepted.
REQ-010 bias  input  BIAS_WIDTH  signed bias, sampled with acc_val.
REQ-011 shift  input  SHIFT_WIDTH  arithmetic right-shift amount, sampled with acc_val.
REQ-012 relu_en  input  1  clamp negatives to zero, sampled with acc_val.
REQ-013 out_data  output  OUT_WIDTH  signed quantized result (FIFO head).
REQ-014 out_val  output  1  out_data valid.
REQ-015 out_rdy  input  1  consumer ready; transfer when out_val && out_rdy.
REQ-016 err_clr  input  1  clears err_overflow.
REQ-017 err_overflow  output  1  sticky: acc_val arrived while acc_rdy was low.
REQ-018 sat_cnt  output  16  count of results clipped by saturation.

Function
REQ-019 Stage 1 SHALL register sum = sign-extended acc + sign-extended bias, width ACC_WIDTH+1, with no overflow possible.
REQ-020 Stage 2 SHALL register sum + 2^(shift-1), arithmetic-shifted right by shift (round half toward +inf); shift==0 passes sum unchanged.
REQ-021 Stage 3 SHALL apply ReLU when relu_en is set, then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and write the result into the FIFO.
REQ-022 bias, shift and relu_en SHALL travel down the pipeline with their operand, so changes after acc_val do not affect in-flight items.
REQ-023 Latency SHALL be exactly 3 cycles from acc_val to out_val when the FIFO is empty.
REQ-024 A credit counter SHALL track in-flight items plus FIFO occupancy; acc_rdy = (credits < FIFO_DEPTH).
REQ-025 An acc_val in the same cycle as an out_val&&out_rdy pop SHALL see the credit freed by that pop (acc_rdy is combinational on the pop).
REQ-026 acc_val while acc_rdy is low SHALL drop the item and set err_overflow; the pipeline and FIFO SHALL be unaffected.
REQ-027 err_clr SHALL clear err_overflow; a new overflow in the same cycle wins, leaving it set.
REQ-028 sat_cnt SHALL increment once per clipped result and hold at 16'hFFFF; a ReLU clamp to zero is not a saturation.
REQ-029 The FIFO SHALL be first-word-fall-through with wrap-around pointers; simultaneous push and pop on a full or empty FIFO SHALL keep the count correct.
REQ-030 out_data SHALL remain stable while out_val is high and out_rdy is low.

Reset
REQ-031 rst SHALL asynchronously clear all pipeline valids, FIFO pointers, credits, err_overflow and sat_cnt.
REQ-032 During and after reset, out_val SHALL be 0, out_data 0, and acc_rdy 1 once rst deasserts.
REQ-033 rst asserted mid-operation SHALL discard all in-flight and buffered items with no partial output.

Structure
REQ-034 Rounding and saturation width constants SHALL live in a shared cnn package, with the MAC output width derived from IMG_WIDTH+KER_WIDTH+1.
REQ-035 The output buffer SHALL be a sub-module named fifo_fwft, parameterised by width and depth.

Verification
REQ-036 acc=1000, bias=24, shift=4, relu_en=0, out_rdy=1 -> out_data=64 exactly 3 cycles later.
REQ-037 acc=-40, bias=0, shift=3 -> out_data=-5 with relu_en=0, and out_data=0 with relu_en=1 and sat_cnt unchanged.
REQ-038 acc=2^20, shift=0 -> out_data=32767 and sat_cnt=1; acc=-2^20 -> out_data=-32768 and sat_cnt=2.
REQ-039 With out_rdy=0, send 5 strobes -> acc_rdy falls after the 4th, the 5th is dropped and sets err_overflow, and out_rdy=1 then yields exactly 4 results in order.
REQ-040 Assert rst asynchronously mid-stream with 2 items buffered -> out_val=0 and out_data=0 immediately, and no stale output after release.
REQ-041 Full FIFO with out_rdy=1 and acc_val in the same cycle -> accepted with no err_overflow, and ordering is preserved.
